stored_carry_accumulator: RTL and testbench

Multi-operand unsigned accumulator built on the stored-carry number system. It accepts a stream of binary operands over a valid/ready handshake and adds each one into a stored-carry register in a single cycle, with no carry propagation. On the last operand it sequences a chunked carry-propagate conversion to binary, then presents the result on an output handshake. It is the controller/sequencer that sits around the team's carry-save adder chain and carry-save-to-binary converter datapath.

---
 rtl/stored_carry_accumulator.sv | 225 ++++++++++++++++++++++
 tb/tb_stored_carry_accumulator.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stored_carry_accumulator.sv
// -----------------------------------------------------------------------------
// stored_carry_accumulator
//
// Multi-operand unsigned accumulator that keeps its running total in
// stored-carry form. Each operand is added in a single cycle with one full
// adder per bit and no carry propagation. On the last operand of a group the
// total is converted to binary CHUNK bits per cycle. The result is then held on
// an output handshake until the consumer takes it.
//
// Parameters
//   LEN    operand / accumulator / result width in bits
//   CHUNK  bits converted per conversion cycle (LEN must be a multiple of CHUNK)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept an operand (high only while accumulating)
//   in_data    unsigned operand
//   in_last    beat is the final operand of the group
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_data   binary sum of the group modulo 2^LEN
//   out_ovf    true group sum was >= 2^LEN (only with SC_ACC_OVF_EN)
//   busy       converting or presenting a result
//
// Build option
//   SC_ACC_OVF_EN  when defined, compiles in the sticky overflow flag that
//                  drives out_ovf. When undefined, dropped carries are
//                  discarded and out_ovf is tied low. out_data is the same
//                  either way.
//
// All outputs are decodes of registered state. There is no combinational path
// from in_valid/out_ready to in_ready/out_valid.
// -----------------------------------------------------------------------------
module stored_carry_accumulator #(
   parameter int unsigned LEN   = 8,
   parameter int unsigned CHUNK = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [LEN-1:0] in_data,
   input  logic           in_last,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [LEN-1:0] out_data,
   output logic           out_ovf,
   output logic           busy
);

   localparam int unsigned NCONV = LEN / CHUNK;
   localparam int unsigned IdxW  = (NCONV > 1) ? $clog2(NCONV) : 1;
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NCONV - 1);

   typedef enum logic [1:0] {
      StAcc,
      StConv,
      StOut
   } stateT;

   stateT           stateQ, stateD;
   // Stored-carry digits: digit i has value accHi[i] + accLo[i], weight 2^i.
   logic [LEN-1:0]  accHiQ, accHiD;
   logic [LEN-1:0]  accLoQ, accLoD;
   logic [LEN-1:0]  resQ, resD;
   logic            cyQ, cyD;
   logic [IdxW-1:0] idxQ, idxD;
`ifdef SC_ACC_OVF_EN
   logic            ovfQ, ovfD;
   logic            dropCarry;
`endif

   // ---------------------------------------------------------------------------
   // Accumulate step: one full adder per digit, carries shifted up one place.
   // ---------------------------------------------------------------------------
   logic [LEN-1:0] faSum;
   logic [LEN-2:0] faCarry;

   assign faSum   = accLoQ ^ accHiQ ^ in_data;
   assign faCarry = (accLoQ[LEN-2:0] & accHiQ[LEN-2:0])
                  | (accLoQ[LEN-2:0] & in_data[LEN-2:0])
                  | (accHiQ[LEN-2:0] & in_data[LEN-2:0]);

`ifdef SC_ACC_OVF_EN
   // Carry out of the top digit has weight 2^LEN; it cannot be stored.
   assign dropCarry = (accLoQ[LEN-1] & accHiQ[LEN-1])
                    | (accLoQ[LEN-1] & in_data[LEN-1])
                    | (accHiQ[LEN-1] & in_data[LEN-1]);
`endif

   // ---------------------------------------------------------------------------
   // Conversion step: ripple-add hi+lo over the chunk selected by idx.
   // ---------------------------------------------------------------------------
   logic [CHUNK-1:0] convHi;
   logic [CHUNK-1:0] convLo;
   logic [CHUNK:0]   convSum;

   always_comb begin
      convHi = '0;
      convLo = '0;
      for (int unsigned k = 0; k < NCONV; k++) begin
         if (idxQ == IdxW'(k)) begin
            convHi = accHiQ[k*CHUNK +: CHUNK];
            convLo = accLoQ[k*CHUNK +: CHUNK];
         end
      end
      convSum = {1'b0, convHi} + {1'b0, convLo} + {{CHUNK{1'b0}}, cyQ};
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      stateD = stateQ;
      accHiD = accHiQ;
      accLoD = accLoQ;
      resD   = resQ;
      cyD    = cyQ;
      idxD   = idxQ;
`ifdef SC_ACC_OVF_EN
      ovfD   = ovfQ;
`endif

      unique case (stateQ)
         StAcc: begin
            // in_ready is high in this state, so in_valid alone is the handshake.
            if (in_valid) begin
               accHiD = faSum;
               accLoD = {faCarry, 1'b0};
`ifdef SC_ACC_OVF_EN
               ovfD   = ovfQ | dropCarry;
`endif
               if (in_last) begin
                  stateD = StConv;
                  idxD   = '0;
                  cyD    = 1'b0;
               end
            end
         end

         StConv: begin
            for (int unsigned k = 0; k < NCONV; k++) begin
               if (idxQ == IdxW'(k)) begin
                  resD[k*CHUNK +: CHUNK] = convSum[CHUNK-1:0];
               end
            end
            cyD = convSum[CHUNK];
            if (idxQ == IdxLast) begin
`ifdef SC_ACC_OVF_EN
               // Final carry-out also has weight 2^LEN.
               ovfD = ovfQ | convSum[CHUNK];
`endif
               stateD = StOut;
            end else begin
               idxD = idxQ + 1'b1;
            end
         end

         StOut: begin
            // res and ovf are untouched here, so the result is stable under
            // back-pressure. The accumulator is cleared for the next group.
            if (out_ready) begin
               stateD = StAcc;
               accHiD = '0;
               accLoD = '0;
               cyD    = 1'b0;
`ifdef SC_ACC_OVF_EN
               ovfD   = 1'b0;
`endif
            end
         end

         default: begin
            stateD = StAcc;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= StAcc;
         accHiQ <= '0;
         accLoQ <= '0;
         resQ   <= '0;
         cyQ    <= 1'b0;
         idxQ   <= '0;
      end else begin
         stateQ <= stateD;
         accHiQ <= accHiD;
         accLoQ <= accLoD;
         resQ   <= resD;
         cyQ    <= cyD;
         idxQ   <= idxD;
      end
   end

`ifdef SC_ACC_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovfQ <= 1'b0;
      end else begin
         ovfQ <= ovfD;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Outputs: decodes of registered state only
   // ---------------------------------------------------------------------------
   assign in_ready  = (stateQ == StAcc);
   assign out_valid = (stateQ == StOut);
   assign busy      = (stateQ != StAcc);
   assign out_data  = resQ;
`ifdef SC_ACC_OVF_EN
   assign out_ovf   = ovfQ;
`else
   assign out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_stored_carry_accumulator.sv
// -----------------------------------------------------------------------------
// Testbench for stored_carry_accumulator (LEN=8, CHUNK=4).
// Expected results come from plain integer sums of the operands driven.
// Overflow expectations follow SC_ACC_OVF_EN as seen by this compilation.
// -----------------------------------------------------------------------------
module tb_stored_carry_accumulator;

   localparam int unsigned LEN = 8;
`ifdef SC_ACC_OVF_EN
   localparam bit OvfEn = 1'b1;
`else
   localparam bit OvfEn = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [LEN-1:0] in_data = '0;
   logic           in_last = 1'b0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [LEN-1:0] out_data;
   logic           out_ovf;
   logic           busy;

   int nCompared = 0;
   int nMismatched = 0;

   stored_carry_accumulator #(
      .LEN   (8),
      .CHUNK (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   // Drive one beat and wait (bounded) until it is accepted.
   // Returns #1 after the accepting edge.
   task automatic send_beat(input logic [7:0] d, input logic last, output bit ok);
      bit acc;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int n = 0; n < 200; n++) begin
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      in_data  = LEN'($urandom);
      in_last  = 1'($urandom);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_data  = LEN'($urandom);
      in_last  = 1'($urandom);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Take one result; out_ready is held low for 'delay' cycles first.
   task automatic collect(input int delay, output logic [7:0] d, output logic o, output bit ok);
      bit hs;
      ok = 1'b0;
      d  = '0;
      o  = 1'b0;
      for (int n = 0; n < 200; n++) begin
         out_ready = (n >= delay);
         hs = out_valid && out_ready;
         d  = out_data;
         o  = out_ovf;
         @(posedge clk);
         #1;
         if (hs) begin
            ok = 1'b1;
            break;
         end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      nCompared++;
      if (in_ready !== 1'b1) begin
         nMismatched++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
      nCompared++;
      if (out_valid !== 1'b0) begin
         nMismatched++;
         $display("FAIL reset_out_valid: got %b, required 0", out_valid);
      end
      nCompared++;
      if (busy !== 1'b0) begin
         nMismatched++;
         $display("FAIL reset_busy: got %b, required 0", busy);
      end
      nCompared++;
      if (out_data !== 8'd0) begin
         nMismatched++;
         $display("FAIL reset_out_data: got %0d, required 0", out_data);
      end
      nCompared++;
      if (out_ovf !== 1'b0) begin
         nMismatched++;
         $display("FAIL reset_out_ovf: got %b, required 0", out_ovf);
      end
   endtask

   // 10+20+30, out_ready held high: checks result, latency and in_ready gap.
   task automatic test_basic();
      bit ok, okAll;
      int lowCnt, firstValid;
      logic [7:0] d;
      logic o;
      lowCnt = 0;
      firstValid = 0;
      d = '0;
      o = 1'b0;
      out_ready = 1'b1;
      send_beat(8'd10, 1'b0, ok);
      okAll = ok;
      send_beat(8'd20, 1'b0, ok);
      okAll &= ok;
      send_beat(8'd30, 1'b1, ok);
      okAll &= ok;
      nCompared++;
      if (okAll !== 1'b1) begin
         nMismatched++;
         $display("FAIL basic_accept: got accepted=%b, required 1", okAll);
      end
      for (int c = 1; c <= 6; c++) begin
         if (!in_ready) lowCnt++;
         if (out_valid && firstValid == 0) begin
            firstValid = c;
            d = out_data;
            o = out_ovf;
         end
         if (c == 1) begin
            nCompared++;
            if (busy !== 1'b1) begin
               nMismatched++;
               $display("FAIL basic_busy: got %b, required 1", busy);
            end
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;
      nCompared++;
      if (d !== 8'd60) begin
         nMismatched++;
         $display("FAIL basic_data: got %0d, required 60", d);
      end
      nCompared++;
      if (o !== 1'b0) begin
         nMismatched++;
         $display("FAIL basic_ovf: got %b, required 0", o);
      end
      nCompared++;
      if (firstValid != 3) begin
         nMismatched++;
         $display("FAIL basic_latency: got out_valid in cycle %0d, required 3", firstValid);
      end
      nCompared++;
      if (lowCnt != 3) begin
         nMismatched++;
         $display("FAIL basic_in_ready_gap: got %0d low cycles, required 3", lowCnt);
      end
   endtask

   task automatic test_overflow();
      bit ok1, ok2, ok3;
      logic [7:0] d;
      logic o;
      send_beat(8'd200, 1'b0, ok1);
      send_beat(8'd100, 1'b1, ok2);
      collect(0, d, o, ok3);
      nCompared++;
      if ((ok1 & ok2 & ok3) !== 1'b1) begin
         nMismatched++;
         $display("FAIL ovf_handshake: got ok=%b%b%b, required 111", ok1, ok2, ok3);
      end
      nCompared++;
      if (d !== 8'd44) begin
         nMismatched++;
         $display("FAIL ovf_data: got %0d, required 44", d);
      end
      nCompared++;
      if (o !== OvfEn) begin
         nMismatched++;
         $display("FAIL ovf_flag: got %b, required %b", o, OvfEn);
      end
   endtask

   // 255 alone, then 1+1: accumulator and sticky flag must clear between groups.
   task automatic test_clear();
      bit ok1, ok2, ok3, ok4;
      logic [7:0] d;
      logic o;
      send_beat(8'd255, 1'b1, ok1);
      collect(1, d, o, ok2);
      nCompared++;
      if ({d, o} !== {8'd255, 1'b0}) begin
         nMismatched++;
         $display("FAIL clear_first: got %0d/%b, required 255/0", d, o);
      end
      send_beat(8'd1, 1'b0, ok3);
      send_beat(8'd1, 1'b1, ok4);
      collect(0, d, o, ok2);
      nCompared++;
      if ({d, o} !== {8'd2, 1'b0}) begin
         nMismatched++;
         $display("FAIL clear_second: got %0d/%b, required 2/0", d, o);
      end
      nCompared++;
      if ((ok1 & ok2 & ok3 & ok4) !== 1'b1) begin
         nMismatched++;
         $display("FAIL clear_handshake: got ok=%b%b%b%b, required 1111", ok1, ok2, ok3, ok4);
      end
   endtask

   // Result held under out_ready=0 while in_valid is asserted with junk.
   task automatic test_backpressure();
      bit ok1, ok2, ok3, seen;
      logic [7:0] d;
      logic o;
      seen = 1'b0;
      out_ready = 1'b0;
      send_beat(8'd200, 1'b0, ok1);
      send_beat(8'd100, 1'b1, ok2);
      for (int n = 0; n < 20; n++) begin
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      nCompared++;
      if (seen !== 1'b1) begin
         nMismatched++;
         $display("FAIL bp_valid_seen: got %b, required 1", seen);
      end
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_data  = LEN'($urandom);
         in_last  = 1'b1;
         @(posedge clk);
         #1;
         nCompared++;
         if ({out_valid, in_ready, out_data, out_ovf} !== {1'b1, 1'b0, 8'd44, OvfEn}) begin
            nMismatched++;
            $display("FAIL bp_hold_%0d: got valid=%b ready=%b data=%0d ovf=%b, required 1 0 44 %b",
                     c, out_valid, in_ready, out_data, out_ovf, OvfEn);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      nCompared++;
      if ({out_valid, in_ready} !== 2'b01) begin
         nMismatched++;
         $display("FAIL bp_release: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
      end
      send_beat(8'd3, 1'b1, ok3);
      collect(0, d, o, ok1);
      nCompared++;
      if ({d, o, ok1, ok2, ok3} !== {8'd3, 1'b0, 3'b111}) begin
         nMismatched++;
         $display("FAIL bp_next_group: got %0d/%b ok=%b%b%b, required 3/0 ok=111",
                  d, o, ok1, ok2, ok3);
      end
   endtask

   // Reset pulse during conversion discards the group.
   task automatic test_reset_mid();
      bit ok1, ok2, ok3;
      bit anyValid;
      logic [7:0] d;
      logic o;
      anyValid = 1'b0;
      send_beat(8'd50, 1'b0, ok1);
      send_beat(8'd60, 1'b1, ok2);
      rst_n = 1'b0;
      #2;
      nCompared++;
      if ({in_ready, out_valid, busy, out_data, out_ovf} !== {3'b100, 8'd0, 1'b0}) begin
         nMismatched++;
         $display("FAIL rstmid_outputs: got ready=%b valid=%b busy=%b data=%0d ovf=%b, required 1 0 0 0 0",
                  in_ready, out_valid, busy, out_data, out_ovf);
      end
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 0; c < 5; c++) begin
         if (out_valid || !in_ready) anyValid = 1'b1;
         @(posedge clk);
         #1;
      end
      nCompared++;
      if (anyValid !== 1'b0) begin
         nMismatched++;
         $display("FAIL rstmid_no_result: got result/busy seen=%b, required 0", anyValid);
      end
      send_beat(8'd7, 1'b1, ok3);
      collect(0, d, o, ok1);
      nCompared++;
      if ({d, o, ok1, ok2, ok3} !== {8'd7, 1'b0, 3'b111}) begin
         nMismatched++;
         $display("FAIL rstmid_next_group: got %0d/%b ok=%b%b%b, required 7/0 ok=111",
                  d, o, ok1, ok2, ok3);
      end
   endtask

   task automatic test_random();
      bit ok, okAll;
      int n, sum;
      logic [7:0] v, d, expD;
      logic o, expO;
      for (int g = 0; g < 20; g++) begin
         n = $urandom_range(1, 20);
         sum = 0;
         okAll = 1'b1;
         for (int i = 0; i < n; i++) begin
            v = 8'($urandom_range(0, 255));
            sum += int'(v);
            idle($urandom_range(0, 2));
            send_beat(v, (i == n - 1), ok);
            okAll &= ok;
         end
         collect($urandom_range(0, 4), d, o, ok);
         okAll &= ok;
         expD = 8'(sum % 256);
         expO = OvfEn && (sum >= 256);
         nCompared++;
         if ({d, o, okAll} !== {expD, expO, 1'b1}) begin
            nMismatched++;
            $display("FAIL random_group_%0d: got %0d/%b ok=%b, required %0d/%b ok=1 (n=%0d sum=%0d)",
                     g, d, o, okAll, expD, expO, n, sum);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      #22;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_overflow();
      test_clear();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
